// File: rtl/bin2bcd_seq_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
package bin2bcd_seq_pkg;

    localparam int W_DEFAULT      = 26;
    localparam int DIGITS_DEFAULT = 8;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/bin2bcd_seq_digit_adj3.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the shift.
module bcd_digit_adj3
    import bin2bcd_seq_pkg::*;
(
    input  bcd_digit_t digit_i,
    output bcd_digit_t digit_o
);

    // 4-bit add; legal digits never exceed 9, so the result stays within the field.
    assign digit_o = (digit_i >= 4'd5) ? bcd_digit_t'(digit_i + 4'd3) : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Optional build macro BIN2BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits to 4'hF.
module bin2bcd_seq
    import bin2bcd_seq_pkg::*;
#(
    parameter int W      = W_DEFAULT,
    parameter int DIGITS = DIGITS_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [W-1:0]          bin,
    output logic                  busy,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid
);

    localparam int BW = 4 * DIGITS;
    localparam int RW = BW + W;
    localparam int CW = $clog2(W + 1);

    state_t          state_q, state_d;
    logic [RW-1:0]   work_q, work_d;
    logic [RW-1:0]   work_adj, work_shl;
    logic [CW-1:0]   count_q, count_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [BW-1:0]   bcd_raw, bcd_fmt;
    logic            valid_q, valid_d;

    // The binary part passes through untouched; each BCD field gets its own corrector.
    assign work_adj[W-1:0] = work_q[W-1:0];

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
            bcd_digit_adj3 u_adj (
                .digit_i (work_q[W + 4*gi +: 4]),
                .digit_o (work_adj[W + 4*gi +: 4])
            );
        end
    endgenerate

    assign work_shl = work_adj << 1;
    assign bcd_raw  = work_shl[RW-1 -: BW];

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    always_comb begin
        logic leading;
        bcd_fmt = bcd_raw;
        leading = 1'b1;
        // Scan from the most significant digit; digit 0 is always shown.
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (leading && (bcd_raw[4*i +: 4] == 4'd0)) begin
                bcd_fmt[4*i +: 4] = BCD_BLANK;
            end else begin
                leading = 1'b0;
            end
        end
    end
`else
    assign bcd_fmt = bcd_raw;
`endif

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    work_d  = {{BW{1'b0}}, bin};
                    count_d = CW'(W);
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                work_d  = work_shl;
                count_d = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    bcd_d   = bcd_fmt;
                    valid_d = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            count_q <= '0;
            bcd_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            bcd_q   <= bcd_d;
            valid_q <= valid_d;
        end
    end

    assign busy      = (state_q == SHIFT);
    assign bcd       = bcd_q;
    assign bcd_valid = valid_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq; expectations follow the active build macro.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [25:0] bin;
    logic        busy;
    logic [31:0] bcd;
    logic        bcd_valid;

    int n_cmp = 0;
    int n_err = 0;

    bin2bcd_seq dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .bin       (bin),
        .busy      (busy),
        .bcd       (bcd),
        .bcd_valid (bcd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef BIN2BCD_LEADING_ZERO_BLANK_EN
    localparam logic [31:0] EXP_ZERO = 32'hFFFFFFF0;
    localparam logic [31:0] EXP_MID  = 32'hF1234567;
    localparam logic [31:0] EXP_999  = 32'hFFFFF999;
    localparam logic [31:0] EXP_777  = 32'hFFFFF777;
    localparam logic [31:0] EXP_42   = 32'hFFFFFF42;
`else
    localparam logic [31:0] EXP_ZERO = 32'h00000000;
    localparam logic [31:0] EXP_MID  = 32'h01234567;
    localparam logic [31:0] EXP_999  = 32'h00000999;
    localparam logic [31:0] EXP_777  = 32'h00000777;
    localparam logic [31:0] EXP_42   = 32'h00000042;
`endif
    localparam logic [31:0] EXP_MAX  = 32'h67108863;
    localparam logic [31:0] EXP_12M  = 32'h12345678;

    // Called at a negedge in IDLE; returns at the negedge after the accepting edge.
    task automatic launch(input logic [25:0] v);
        start = 1'b1;
        bin   = v;
        @(negedge clk);
        start = 1'b0;
        bin   = 26'h2AAAAAA;
    endtask

    // Samples 40 cycles after acceptance; optionally drives a stray start at sample inject_k.
    task automatic measure(input int inject_k, input logic [25:0] inject_bin,
                           output int n_valid, output int n_busy, output int lat,
                           output logic [31:0] res);
        n_valid = 0;
        n_busy  = 0;
        lat     = -1;
        res     = 32'hDEADBEEF;
        for (int k = 1; k <= 40; k++) begin
            if (busy) n_busy++;
            if (bcd_valid) begin
                n_valid++;
                if (lat < 0) begin
                    lat = k - 1;
                    res = bcd;
                end
            end
            if (k == inject_k) begin
                start = 1'b1;
                bin   = inject_bin;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
    endtask

    task automatic check_conv(input string name, input logic [25:0] v, input logic [31:0] exp_bcd,
                              input int inject_k, input logic [25:0] inject_bin);
        int nv, nb, lat;
        logic [31:0] res;
        launch(v);
        measure(inject_k, inject_bin, nv, nb, lat, res);
        $display("conv %s: bin=%0d bcd=%h valid_pulses=%0d busy_cycles=%0d latency=%0d",
                 name, v, res, nv, nb, lat);
        n_cmp++;
        if (res !== exp_bcd) begin
            n_err++;
            $display("FAIL %s_bcd: got %h expected %h", name, res, exp_bcd);
        end
        n_cmp++;
        if (nv !== 1) begin
            n_err++;
            $display("FAIL %s_pulses: got %0d expected 1", name, nv);
        end
        n_cmp++;
        if (nb !== 26) begin
            n_err++;
            $display("FAIL %s_busy: got %0d expected 26", name, nb);
        end
        n_cmp++;
        if (lat !== 26) begin
            n_err++;
            $display("FAIL %s_latency: got %0d expected 26", name, lat);
        end
        n_cmp++;
        if (bcd !== exp_bcd) begin
            n_err++;
            $display("FAIL %s_hold: got %h expected %h", name, bcd, exp_bcd);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        bin   = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        $display("reset: busy=%b bcd=%h bcd_valid=%b", busy, bcd, bcd_valid);
        n_cmp++;
        if ({busy, bcd_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_flags: got busy=%b valid=%b expected 0 0", busy, bcd_valid);
        end
        n_cmp++;
        if (bcd !== 32'h0) begin
            n_err++;
            $display("FAIL reset_bcd: got %h expected 00000000", bcd);
        end
    endtask

    task automatic test_values();
        check_conv("zero", 26'd0, EXP_ZERO, 0, '0);
        check_conv("max", 26'd67108863, EXP_MAX, 0, '0);
        check_conv("mid", 26'd1234567, EXP_MID, 0, '0);
    endtask

    task automatic test_start_while_busy();
        check_conv("ignore", 26'd999, EXP_999, 10, 26'd5);
    endtask

    task automatic test_back_to_back();
        int t_first, t_second, n_valid;
        logic [31:0] r_first, r_second;
        t_first  = -1;
        t_second = -1;
        n_valid  = 0;
        r_first  = '0;
        r_second = '0;
        launch(26'd777);
        for (int k = 1; k <= 70; k++) begin
            start = 1'b0;
            if (bcd_valid) begin
                n_valid++;
                if (t_first < 0) begin
                    t_first = k;
                    r_first = bcd;
                    start   = 1'b1;
                    bin     = 26'd42;
                end else if (t_second < 0) begin
                    t_second = k;
                    r_second = bcd;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        $display("b2b: first=%h at %0d second=%h at %0d pulses=%0d",
                 r_first, t_first, r_second, t_second, n_valid);
        n_cmp++;
        if (r_first !== EXP_777) begin
            n_err++;
            $display("FAIL b2b_first: got %h expected %h", r_first, EXP_777);
        end
        n_cmp++;
        if (r_second !== EXP_42) begin
            n_err++;
            $display("FAIL b2b_second: got %h expected %h", r_second, EXP_42);
        end
        n_cmp++;
        if ((t_second - t_first) !== 27 || t_first < 0 || t_second < 0) begin
            n_err++;
            $display("FAIL b2b_spacing: got %0d expected 27", t_second - t_first);
        end
        n_cmp++;
        if (n_valid !== 2) begin
            n_err++;
            $display("FAIL b2b_pulses: got %0d expected 2", n_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n_valid;
        launch(26'd12345678);
        repeat (12) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL midrst_busy_before: got %b expected 1", busy);
        end
        rst_n = 1'b0;
        #1;
        $display("midrst: busy=%b bcd=%h bcd_valid=%b", busy, bcd, bcd_valid);
        n_cmp++;
        if ({busy, bcd_valid} !== 2'b00) begin
            n_err++;
            $display("FAIL midrst_flags: got busy=%b valid=%b expected 0 0", busy, bcd_valid);
        end
        n_cmp++;
        if (bcd !== 32'h0) begin
            n_err++;
            $display("FAIL midrst_bcd: got %h expected 00000000", bcd);
        end
        @(negedge clk);
        rst_n = 1'b1;
        n_valid = 0;
        for (int k = 0; k < 40; k++) begin
            if (bcd_valid || busy) n_valid++;
            @(negedge clk);
        end
        n_cmp++;
        if (n_valid !== 0) begin
            n_err++;
            $display("FAIL midrst_quiet: got %0d active cycles expected 0", n_valid);
        end
        check_conv("after_rst", 26'd12345678, EXP_12M, 0, '0);
    endtask

    initial begin
        test_reset();
        test_values();
        test_start_while_busy();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
